// File: rtl/router_output_scheduler_pkg.sv
// Shared constants, flit field layout and scheduler state encoding for the
// router output scheduler slice.
package router_pkg;

   localparam int FLIT_WIDTH  = 68;

   localparam int FLIT_VALID  = 0;
   localparam int FLIT_HEAD   = 1;
   localparam int FLIT_TAIL   = 2;
   localparam int PAYLOAD_LSB = 3;

   localparam int FLOW_CREDIT = 0;

   localparam int CREDIT_W    = 4;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } sched_state_e;

endpackage

// File: rtl/router_rr_arbiter.sv
// Combinational round-robin search: grants the first requester at or after
// the pointer, wrapping cyclically.
module router_rr_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int PTR_W     = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] grant,
   output logic [PTR_W-1:0]     grant_idx,
   output logic                 grant_any
);

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(ptr) + i) % NUM_PORTS;
         if (!grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PTR_W'(idx);
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_output_scheduler.sv
// Wormhole output scheduler: round-robin on head flits, lock to the winner
// until its tail, credit-based flow control toward the downstream router.
module router_output_scheduler
   import router_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int FLIT_WIDTH = router_pkg::FLIT_WIDTH,
   parameter int CREDIT_MAX = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [NUM_PORTS-1:0]            in_valid,
   output logic [NUM_PORTS-1:0]            in_pop,
   input  logic [0:1]                      flow_ctrl_in_op,
   output logic [0:FLIT_WIDTH-1]           channel_out_op,
   output logic                            error
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [CREDIT_W-1:0] CREDIT_RST = CREDIT_W'(CREDIT_MAX);

   // Saturating credit update; a return at full credit is held at the limit.
   function automatic logic [CREDIT_W-1:0] credit_update(
      input logic [CREDIT_W-1:0] cur,
      input logic                dec,
      input logic                inc
   );
      logic [CREDIT_W-1:0] nxt;
      nxt = cur;
      if (dec && !inc)
         nxt = cur - CREDIT_W'(1);
      else if (inc && !dec && (cur != CREDIT_RST))
         nxt = cur + CREDIT_W'(1);
      return nxt;
   endfunction

   sched_state_e            state, state_nxt;
   logic [PTR_W-1:0]        owner, owner_nxt;
   logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
   logic [CREDIT_W-1:0]     credits;

   logic [FLIT_WIDTH-1:0]   flit [NUM_PORTS];
   logic [NUM_PORTS-1:0]    head_req;
   logic [NUM_PORTS-1:0]    grant;
   logic [PTR_W-1:0]        grant_idx;
   logic                    grant_any;

   logic [PTR_W-1:0]        sel_idx;
   logic [FLIT_WIDTH-1:0]   out_p0;
   logic                    vld_p0;
   logic                    drop_p0;
   logic                    credit_ret;
   logic                    credit_ovf;
   logic                    can_send;
   logic                    unused_flow;

   assign unused_flow = flow_ctrl_in_op[1];
   assign credit_ret  = flow_ctrl_in_op[FLOW_CREDIT];
   assign can_send    = (credits != '0);

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         flit[p]     = in_flit[p*FLIT_WIDTH +: FLIT_WIDTH];
         head_req[p] = in_valid[p] & flit[p][FLIT_HEAD];
      end
   end

   router_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_W     (PTR_W)
   ) u_arb (
      .req       (head_req),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Stage p0: select, pop and decide next state in the same cycle.
   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      in_pop     = '0;
      vld_p0     = 1'b0;
      drop_p0    = 1'b0;
      sel_idx    = grant_idx;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (grant_any && can_send) begin
                  vld_p0     = 1'b1;
                  in_pop     = grant;
                  rr_ptr_nxt = (grant_idx == PTR_W'(NUM_PORTS-1)) ? '0 : grant_idx + PTR_W'(1);
                  if (!flit[grant_idx][FLIT_TAIL]) begin
                     state_nxt = LOCKED;
                     owner_nxt = grant_idx;
                  end
               end
            end
            LOCKED: begin
               sel_idx = owner;
               if (in_valid[owner]) begin
                  if (flit[owner][FLIT_HEAD]) begin
                     drop_p0       = 1'b1;
                     in_pop[owner] = 1'b1;
                  end else if (can_send) begin
                     vld_p0        = 1'b1;
                     in_pop[owner] = 1'b1;
                     if (flit[owner][FLIT_TAIL])
                        state_nxt = IDLE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      out_p0 = '0;
      if (vld_p0) begin
         out_p0             = flit[sel_idx];
         out_p0[FLIT_VALID] = 1'b1;
      end
   end

   assign credit_ovf = credit_ret && !vld_p0 && (credits == CREDIT_RST);

   // Stage p1: registered channel output and control state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         owner          <= '0;
         rr_ptr         <= '0;
         credits        <= CREDIT_RST;
         error          <= 1'b0;
         channel_out_op <= '0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         rr_ptr  <= rr_ptr_nxt;
         credits <= credit_update(credits, vld_p0, credit_ret);
         error   <= error | drop_p0 | credit_ovf;
         for (int i = 0; i < FLIT_WIDTH; i++)
            channel_out_op[i] <= out_p0[i];
      end
   end

endmodule
